// File: rtl/poly_coeff_buf_if.sv
// Coefficient bus between the rejection-sampling parser, the coefficient
// buffer and the downstream NTT/accumulator consumer.
interface poly_coeff_buf_if;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        i_done;
    logic        o_wr_ready;
    logic [11:0] o_coeff;
    logic [7:0]  o_coeff_idx;
    logic        o_coeff_valid;
    logic        i_coeff_ready;
    logic        o_last;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_coeffs, i_coeffs_valid, i_done, i_coeff_ready,
        input  o_wr_ready, o_coeff, o_coeff_idx, o_coeff_valid, o_last, o_done, o_err
    );

    modport slave (
        input  i_coeffs, i_coeffs_valid, i_done, i_coeff_ready,
        output o_wr_ready, o_coeff, o_coeff_idx, o_coeff_valid, o_last, o_done, o_err
    );
endinterface

// File: rtl/poly_coeff_buf.sv
// Buffers one 256-coefficient polynomial arriving four lanes per word and
// drains it one coefficient per cycle in index order; sticky error on misuse.
module poly_coeff_buf #(
    parameter int N     = 256,
    parameter int Q     = 3329,
    parameter int CW    = 12,
    parameter int LANES = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    poly_coeff_buf_if.slave bus
);
    localparam int WORDS = N / LANES;
    localparam logic [CW-1:0] QV = CW'(Q);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t                   state_q;
    logic [6:0]               wrCnt_q;
    logic [7:0]               rdCnt_q;
    logic [LANES*CW-1:0]      mem_q [WORDS];
    logic                     done_q;
    logic                     err_q;

    logic                     laneBad;
    logic [LANES*CW-1:0]      rdWord;
    logic [CW-1:0]            rdLane;

    always_comb begin
        laneBad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (bus.i_coeffs[(LANES-1-l)*CW +: CW] >= QV) laneBad = 1'b1;
        end
    end

    // Lane 0 sits in the most significant slice of each stored word.
    always_comb begin
        rdWord = mem_q[rdCnt_q[7:2]];
        rdLane = '0;
        for (int l = 0; l < LANES; l++) begin
            if (rdCnt_q[1:0] == 2'(l)) rdLane = rdWord[(LANES-1-l)*CW +: CW];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_FILL;
            wrCnt_q <= '0;
            rdCnt_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (bus.i_coeffs_valid) begin
                        mem_q[wrCnt_q[5:0]] <= bus.i_coeffs;
                        if (laneBad) err_q <= 1'b1;
                        // A same-cycle i_done is harmless only if this write completes the polynomial.
                        if (wrCnt_q == 7'(WORDS - 1)) begin
                            state_q <= S_DRAIN;
                            rdCnt_q <= '0;
                            wrCnt_q <= 7'(WORDS);
                        end else if (bus.i_done) begin
                            err_q   <= 1'b1;
                            wrCnt_q <= '0;
                        end else begin
                            wrCnt_q <= wrCnt_q + 7'd1;
                        end
                    end else if (bus.i_done && wrCnt_q != 7'd0) begin
                        err_q   <= 1'b1;
                        wrCnt_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (bus.i_coeffs_valid) err_q <= 1'b1;
                    if (bus.i_coeff_ready) begin
                        rdCnt_q <= rdCnt_q + 8'd1;
                        if (rdCnt_q == 8'(N - 1)) begin
                            state_q <= S_FILL;
                            wrCnt_q <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign bus.o_wr_ready    = (state_q == S_FILL);
    assign bus.o_coeff_valid = (state_q == S_DRAIN);
    assign bus.o_coeff       = (state_q == S_DRAIN) ? rdLane : '0;
    assign bus.o_coeff_idx   = rdCnt_q;
    assign bus.o_last        = (state_q == S_DRAIN) && (rdCnt_q == 8'(N - 1));
    assign bus.o_done        = done_q;
    assign bus.o_err         = err_q;
endmodule

// File: tb/tb_poly_coeff_buf.sv
// Directed bench for poly_coeff_buf: fill/drain, back-pressure, gaps, errors,
// overrun, simultaneous done and mid-drain reset.
module tb_poly_coeff_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   expMem [256];

    poly_coeff_buf_if bus();

    poly_coeff_buf dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic applyReset();
        bus.i_coeffs       = '0;
        bus.i_coeffs_valid = 1'b0;
        bus.i_done         = 1'b0;
        bus.i_coeff_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    // pattern 0: lane value = index; 1: lane0 = 3328 others 0; 2: as 0 but word 5 lane 2 = 3329
    task automatic fillPoly(input int pattern, input int gap, input bit doneWithLast, input string name);
        logic [11:0] lv [4];
        for (int w = 0; w < 64; w++) begin
            for (int l = 0; l < 4; l++) begin
                case (pattern)
                    1:       lv[l] = (l == 0) ? 12'd3328 : 12'd0;
                    2:       lv[l] = (w == 5 && l == 2) ? 12'd3329 : 12'(4*w + l);
                    default: lv[l] = 12'(4*w + l);
                endcase
                expMem[4*w + l] = int'(lv[l]);
            end
            if (w != 0) begin
                repeat (gap) begin
                    bus.i_coeffs_valid = 1'b0;
                    @(negedge clk);
                end
            end
            if (w == 63) begin
                testsRun++;
                if (bus.o_coeff_valid !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s early_valid: got %0b expected 0", name, bus.o_coeff_valid);
                end
            end
            bus.i_coeffs       = {lv[0], lv[1], lv[2], lv[3]};
            bus.i_coeffs_valid = 1'b1;
            bus.i_done         = doneWithLast && (w == 63);
            @(negedge clk);
        end
        bus.i_coeffs_valid = 1'b0;
        bus.i_done         = 1'b0;
        testsRun++;
        if (bus.o_coeff_valid !== 1'b1 || bus.o_coeff_idx !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL %s drain_start: got valid=%0b idx=%0d expected valid=1 idx=0",
                     name, bus.o_coeff_valid, bus.o_coeff_idx);
        end
    endtask

    // Called at a negedge with the first drain beat visible; stopAt >= 0 returns with that index showing.
    task automatic drainPoly(input int readyMode, input int injectAt, input int stopAt, input string name);
        int expIdx = 0;
        int cyc = 0;
        bit injected = 1'b0;
        bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (expIdx < 256 && cyc < 3000) begin
            testsRun++;
            if (bus.o_coeff_valid !== 1'b1 || bus.o_coeff_idx !== 8'(expIdx)) begin
                testsFailed++;
                $display("[TB] FAIL %s idx: got valid=%0b idx=%0d expected valid=1 idx=%0d",
                         name, bus.o_coeff_valid, bus.o_coeff_idx, expIdx);
            end
            testsRun++;
            if (bus.o_coeff !== 12'(expMem[expIdx])) begin
                testsFailed++;
                $display("[TB] FAIL %s data[%0d]: got %0d expected %0d", name, expIdx, bus.o_coeff, expMem[expIdx]);
            end
            testsRun++;
            if (bus.o_last !== (expIdx == 255) || bus.o_done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s last/done[%0d]: got last=%0b done=%0b expected last=%0b done=0",
                         name, expIdx, bus.o_last, bus.o_done, (expIdx == 255));
            end
            if (stopAt >= 0 && expIdx == stopAt) begin
                bus.i_coeff_ready = 1'b0;
                return;
            end
            bus.i_coeff_ready = (readyMode == 1) ? rp[cyc % 4] : 1'b1;
            if (injectAt >= 0 && !injected && expIdx == injectAt) begin
                bus.i_coeffs       = 48'hABC_ABC_ABC_ABC;
                bus.i_coeffs_valid = 1'b1;
                injected           = 1'b1;
            end else begin
                bus.i_coeffs_valid = 1'b0;
            end
            if (bus.i_coeff_ready) expIdx++;
            cyc++;
            @(negedge clk);
        end
        bus.i_coeff_ready  = 1'b0;
        bus.i_coeffs_valid = 1'b0;
        testsRun++;
        if (cyc >= 3000) begin
            testsFailed++;
            $display("[TB] FAIL %s timeout: got %0d coefficients expected 256", name, expIdx);
        end
        testsRun++;
        if (bus.o_done !== 1'b1 || bus.o_wr_ready !== 1'b1 || bus.o_coeff_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s done_pulse: got done=%0b wr_ready=%0b valid=%0b expected 1 1 0",
                     name, bus.o_done, bus.o_wr_ready, bus.o_coeff_valid);
        end
        @(negedge clk);
        checkBit({name, " done_clear"}, bus.o_done, 1'b0);
    endtask

    task automatic test_reset();
        applyReset();
        checkBit("reset wr_ready", bus.o_wr_ready, 1'b1);
        checkBit("reset valid", bus.o_coeff_valid, 1'b0);
        checkBit("reset last", bus.o_last, 1'b0);
        checkBit("reset done", bus.o_done, 1'b0);
        checkBit("reset err", bus.o_err, 1'b0);
        testsRun++;
        if (bus.o_coeff !== 12'd0 || bus.o_coeff_idx !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset data: got coeff=%0d idx=%0d expected 0 0", bus.o_coeff, bus.o_coeff_idx);
        end
    endtask

    task automatic test_sequential();
        applyReset();
        fillPoly(0, 0, 1'b0, "seq");
        drainPoly(0, -1, -1, "seq");
        checkBit("seq err", bus.o_err, 1'b0);
    endtask

    task automatic test_back_pressure();
        applyReset();
        fillPoly(0, 0, 1'b0, "bp");
        drainPoly(1, -1, -1, "bp");
        checkBit("bp err", bus.o_err, 1'b0);
    endtask

    task automatic test_gapped();
        applyReset();
        fillPoly(1, 2, 1'b0, "gap");
        drainPoly(0, -1, -1, "gap");
        checkBit("gap err", bus.o_err, 1'b0);
    endtask

    task automatic test_range_error();
        applyReset();
        fillPoly(2, 0, 1'b0, "range");
        checkBit("range err", bus.o_err, 1'b1);
        drainPoly(0, -1, -1, "range");
    endtask

    task automatic test_short_poly();
        applyReset();
        for (int w = 0; w < 10; w++) begin
            bus.i_coeffs       = 48'h001_002_003_004;
            bus.i_coeffs_valid = 1'b1;
            @(negedge clk);
        end
        bus.i_coeffs_valid = 1'b0;
        bus.i_done         = 1'b1;
        @(negedge clk);
        bus.i_done = 1'b0;
        checkBit("short err", bus.o_err, 1'b1);
        checkBit("short wr_ready", bus.o_wr_ready, 1'b1);
        fillPoly(0, 0, 1'b0, "short_refill");
        drainPoly(0, -1, -1, "short_refill");
        checkBit("short err sticky", bus.o_err, 1'b1);
    endtask

    task automatic test_overrun();
        applyReset();
        fillPoly(0, 0, 1'b0, "ovr");
        checkBit("ovr err_before", bus.o_err, 1'b0);
        drainPoly(0, 50, -1, "ovr");
        checkBit("ovr err_after", bus.o_err, 1'b1);
    endtask

    task automatic test_simultaneous_done();
        applyReset();
        fillPoly(0, 0, 1'b1, "simul");
        checkBit("simul err_fill", bus.o_err, 1'b0);
        drainPoly(0, -1, -1, "simul");
        checkBit("simul err_drain", bus.o_err, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        applyReset();
        fillPoly(0, 0, 1'b0, "mid");
        drainPoly(0, -1, 100, "mid");
        rst = 1'b1;
        #1;
        checkBit("mid rst valid", bus.o_coeff_valid, 1'b0);
        checkBit("mid rst last", bus.o_last, 1'b0);
        checkBit("mid rst done", bus.o_done, 1'b0);
        checkBit("mid rst err", bus.o_err, 1'b0);
        checkBit("mid rst wr_ready", bus.o_wr_ready, 1'b1);
        testsRun++;
        if (bus.o_coeff !== 12'd0 || bus.o_coeff_idx !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL mid rst data: got coeff=%0d idx=%0d expected 0 0", bus.o_coeff, bus.o_coeff_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fillPoly(0, 0, 1'b0, "mid_refill");
        drainPoly(0, -1, -1, "mid_refill");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_back_pressure();
        test_gapped();
        test_range_error();
        test_short_poly();
        test_overrun();
        test_simultaneous_done();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/poly_coeff_buf.md
# poly_coeff_buf

Polynomial coefficient buffer directly downstream of the rejection-sampling parser. Captures 64 words of four 12-bit coefficients (256 coefficients, one Kyber polynomial) from the parser's coefficient output, then streams them out one coefficient per cycle, in natural index order, over a valid/ready handshake to the NTT or accumulator stage. Flags protocol violations (overrun, short polynomial, out-of-range coefficient) on a sticky error bit.

## Interface
- N, 256, coefficients per polynomial
- Q, 3329, modulus; every accepted coefficient must be < Q
- CW, 12, coefficient width
- LANES, 4, coefficients per input word

- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_coeffs  input  48  four coefficients; lane 0 (index 4w) in [47:36], lane 3 (index 4w+3) in [11:0]
- i_coeffs_valid  input  1  one-cycle qualifier for i_coeffs
- i_done  input  1  parser end-of-polynomial pulse
- o_wr_ready  output  1  high in S_FILL; advisory only, the parser has no back-pressure
- o_coeff  output  12  drained coefficient
- o_coeff_idx  output  8  index of o_coeff (0..255)
- o_coeff_valid  output  1  o_coeff/o_coeff_idx valid
- i_coeff_ready  input  1  consumer accepts when high together with o_coeff_valid
- o_last  output  1  high with o_coeff_valid when o_coeff_idx == 255
- o_done  output  1  one-cycle pulse after the final transfer
- o_err  output  1  sticky error, cleared only by reset

## Operation
- Storage: 64 x 48-bit register array, `mem[wr_cnt]`. Word w holds coefficients 4w..4w+3.
- Counters: wr_cnt is 7 bits (0..64). rd_cnt is 8 bits (0..255).
- States:
  - S_FILL, the reset state.
    - Each cycle with i_coeffs_valid: write `mem[wr_cnt]` and increment wr_cnt.
    - On the write that makes wr_cnt reach 64: go to S_DRAIN and set rd_cnt = 0.
    - If any lane of i_coeffs is >= Q: store the word anyway and set o_err.
    - i_done with 0 < wr_cnt < 64 (short polynomial): set o_err and reset wr_cnt to 0. Already-written words are discarded.
    - i_done with wr_cnt == 0: ignored.
    - Same-cycle i_done and i_coeffs_valid: the write happens first. If that write completes word 63, go to S_DRAIN with no error. Otherwise the short-poly rule applies.
  - S_DRAIN.
    - o_coeff_valid = 1.
    - o_coeff = lane (rd_cnt[1:0]) of `mem[rd_cnt[7:2]]`.
    - o_coeff_idx = rd_cnt.
    - On a transfer (valid & ready): increment rd_cnt.
    - Transfer with rd_cnt == 255: go to S_FILL, set wr_cnt = 0, pulse o_done next cycle.
    - i_coeffs_valid in S_DRAIN (overrun): word dropped, o_err set.
    - i_done in S_DRAIN: ignored.
- o_coeff, o_coeff_idx and o_last are driven only from state and registers, with no combinational path from inputs.
- o_coeff_valid, o_coeff and o_coeff_idx stay stable while i_coeff_ready is low.
- Reset (asynchronous, any time, including mid-fill or mid-drain):
  - state = S_FILL; wr_cnt = 0; rd_cnt = 0; mem cleared to 0.
  - Outputs: o_wr_ready = 1; o_coeff = 0, o_coeff_idx = 0, o_coeff_valid = 0, o_last = 0, o_done = 0, o_err = 0.

## Timing
- Write: i_coeffs sampled on the rising edge where i_coeffs_valid = 1. Zero-bubble, one word per cycle.
- Fill to drain: the 64th write edge moves the state to S_DRAIN. o_coeff_valid = 1 with idx 0 in the next cycle, i.e. one cycle of latency.
- Drain: 256 cycles minimum when i_coeff_ready is held high.
- o_done: asserted the cycle after the idx-255 transfer. o_wr_ready = 1 in the same cycle.
- Back-to-back polynomials: a new fill may start in the cycle o_done is high.
- Minimum polynomial period: 64 fill + 256 drain = 320 cycles.

## Test plan
- Sequential fill: reset, then 64 consecutive valid words, word w = {4w, 4w+1, 4w+2, 4w+3}, then ready held high.
  - Required: o_coeff_valid first high one cycle after the 64th write.
  - o_coeff == o_coeff_idx for 0..255.
  - o_last only at idx 255; o_done one cycle later; o_err = 0.
- Back-pressure: as the sequential fill, with ready toggling 1-0-0-1 repeatedly.
  - Required: all 256 values delivered in order, none skipped or duplicated.
  - Outputs hold while ready is low.
- Gapped input: valid every third cycle; lane 0 of each word = 3328, other lanes = 0.
  - Required: drained values at idx % 4 == 0 are 3328, all others 0.
  - No error.
- Errors:
  - A word with lane 2 = 3329 → o_err = 1, and the stored value 3329 is drained at that index.
  - Separately, after reset: 10 words then i_done → o_err = 1, wr_cnt returns to 0. A following full 64-word poly then drains correctly.
- Overrun and simultaneous events:
  - A valid word during S_DRAIN → dropped, o_err set, drain data unaffected.
  - The 64th word together with i_done → normal drain, o_err = 0.
- Reset mid-drain: assert i_rst at idx 100.
  - Required: all outputs 0 immediately, o_wr_ready = 1.
  - A subsequent full polynomial drains from idx 0.
